mux_nto1_scan: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer; the successor to the team's fixed 4-to-1 single-bit muxes. Channel selection is captured through a valid-qualified select port and held until changed. An optional auto-scan mode steps through all channels with a programmable dwell. Used wherever a datapath must time-share one W-bit consumer across N sources with a registered, glitch-free output and an accompanying channel tag.

---
 rtl/mux_pkg.sv | 20 ++
 rtl/mux_scan_ctr.sv | 45 ++++
 rtl/mux_nto1_scan.sv | 129 ++++++++++++
 tb/tb_mux_nto1_scan.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and state encoding for mux_nto1_scan
package mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } mux_state_e;

    // Dwell counter width; DWELL-1 up to 255 fits in 8 bits.
    localparam int DWELL_CW  = 8;

    localparam int N_MIN     = 2;
    localparam int N_MAX     = 64;
    localparam int W_MIN     = 1;
    localparam int W_MAX     = 64;
    localparam int DWELL_MIN = 1;
    localparam int DWELL_MAX = 256;

endpackage

// File: rtl/mux_scan_ctr.sv
// rtl/mux_scan_ctr.sv - dwell counter and wrapping channel stepper for scan mode (MUX_SCAN_EN builds only)
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : force dwell counter to 0 (outside SCAN or leaving it)
//   enable    : count this cycle (in SCAN with mode held high)
//   cur_ch    : channel currently selected
//   next_ch   : cur_ch + 1, wrapping N-1 -> 0
//   step      : high on the last dwell cycle; owner advances to next_ch
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int DWELL = 1,
    parameter int SELW  = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            enable,
    input  logic [SELW-1:0] cur_ch,
    output logic [SELW-1:0] next_ch,
    output logic            step
);

    localparam logic [DWELL_CW-1:0] LAST_CNT = DWELL_CW'(DWELL - 1);
    localparam logic [SELW-1:0]     LAST_CH  = SELW'(N - 1);

    logic [DWELL_CW-1:0] dwell_cnt;

    assign step    = enable && (dwell_cnt == LAST_CNT);
    // Explicit wrap so non-power-of-2 N never visits an unused code.
    assign next_ch = (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt <= '0;
        end else if (clear || step) begin
            dwell_cnt <= '0;
        end else if (enable) begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_nto1_scan.sv
// rtl/mux_nto1_scan.sv - N-channel W-bit registered mux with held select and optional auto-scan
//
// Optional feature: define MUX_SCAN_EN to build the SCAN state and dwell counter;
// otherwise mode is ignored and the block runs IDLE/HOLD only.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   in_data   : N*W, channel k at [k*W +: W]
//   sel       : requested channel, captured when sel_valid
//   sel_valid : capture sel this cycle
//   mode      : 0 manual hold, 1 auto-scan
//   out_data  : registered data of the selected channel
//   out_ch    : channel that produced out_data
//   out_valid : out_data/out_ch meaningful (HOLD or SCAN)
//   sel_err   : one-cycle pulse after sel_valid with sel >= N
module mux_nto1_scan
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DWELL = 1,
    parameter int SELW  = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [SELW-1:0] sel,
    input  logic            sel_valid,
    input  logic            mode,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_ch,
    output logic            out_valid,
    output logic            sel_err
);

    localparam logic [SELW:0] N_EXT = (SELW + 1)'(N);

    mux_state_e      state, state_n;
    logic [SELW-1:0] cur_ch, cur_n;
    logic            err_n;
    logic            sel_ok;
    logic            scan_req;
    logic            step;
    logic [SELW-1:0] next_ch;
    logic [W-1:0]    ch_data [N];

    for (genvar k = 0; k < N; k++) begin : g_ch
        assign ch_data[k] = in_data[k*W +: W];
    end

    assign sel_ok = sel_valid && ({1'b0, sel} < N_EXT);

`ifdef MUX_SCAN_EN
    assign scan_req = mode;

    // Counter is cleared whenever this cycle does not continue a scan, which
    // covers both SCAN entry and the SCAN -> HOLD exit.
    mux_scan_ctr #(
        .N     (N),
        .DWELL (DWELL),
        .SELW  (SELW)
    ) u_scan_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (!((state == ST_SCAN) && mode)),
        .enable  ((state == ST_SCAN) && mode),
        .cur_ch  (cur_ch),
        .next_ch (next_ch),
        .step    (step)
    );
`else
    logic unused_scan;
    assign scan_req    = 1'b0;
    assign step        = 1'b0;
    assign next_ch     = '0;
    assign unused_scan = mode;
`endif

    always_comb begin
        state_n = state;
        cur_n   = cur_ch;
        err_n   = 1'b0;
        case (state)
            ST_IDLE, ST_HOLD: begin
                // Scan request takes priority; a coincident sel is discarded.
                if (scan_req) begin
                    state_n = ST_SCAN;
                    cur_n   = '0;
                end else if (sel_ok) begin
                    state_n = ST_HOLD;
                    cur_n   = sel;
                end else if (sel_valid) begin
                    err_n   = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!scan_req) begin
                    state_n = ST_HOLD;
                end else if (step) begin
                    cur_n   = next_ch;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_ch    <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            state   <= state_n;
            cur_ch  <= cur_n;
            sel_err <= err_n;
            if (state != ST_IDLE) begin
                out_data  <= ch_data[cur_ch];
                out_ch    <= cur_ch;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_scan.sv
// tb/tb_mux_nto1_scan.sv - scoreboard bench for mux_nto1_scan (N=3, W=8, DWELL=3)
module tb_mux_nto1_scan;

    localparam int N     = 3;
    localparam int W     = 8;
    localparam int DWELL = 3;
    localparam int SELW  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*W-1:0]  in_data = '0;
    logic [SELW-1:0] sel = '0;
    logic            sel_valid = 1'b0;
    logic            mode = 1'b0;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_ch;
    logic            out_valid;
    logic            sel_err;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0]    d;
        logic [SELW-1:0] ch;
        logic            v;
        logic            e;
    } exp_t;

    exp_t q[$];

    // reference model state
    int          m_state = 0;   // 0 idle, 1 hold, 2 scan
    int          m_cur = 0;
    int          m_cnt = 0;
    logic [W-1:0] m_od = '0;
    int          m_och = 0;
    logic        m_ov = 1'b0;
    logic        m_err = 1'b0;

`ifdef MUX_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    int scan_seq [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};

    mux_nto1_scan #(
        .N     (N),
        .W     (W),
        .DWELL (DWELL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .sel       (sel),
        .sel_valid (sel_valid),
        .mode      (mode),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cur = 0; m_cnt = 0;
        m_od = '0; m_och = 0; m_ov = 1'b0; m_err = 1'b0;
        q.delete();
    endtask

    // Advance the model by one edge using the inputs currently driven and
    // push the outputs it predicts for after that edge.
    task automatic model_edge();
        bit   req;
        exp_t e;
        req = SCAN_EN && mode;
        if (m_state != 0) begin
            m_od  = in_data[m_cur*W +: W];
            m_och = m_cur;
            m_ov  = 1'b1;
        end else begin
            m_ov  = 1'b0;
        end
        m_err = 1'b0;
        if (m_state == 2) begin
            if (!mode) begin
                m_state = 1; m_cnt = 0;
            end else if (m_cnt == DWELL - 1) begin
                m_cnt = 0; m_cur = (m_cur + 1) % N;
            end else begin
                m_cnt++;
            end
        end else if (req) begin
            m_state = 2; m_cur = 0; m_cnt = 0;
        end else if (sel_valid) begin
            if (int'(sel) < N) begin
                m_state = 1; m_cur = int'(sel);
            end else begin
                m_err = 1'b1;
            end
        end
        e.d = m_od; e.ch = SELW'(m_och); e.v = m_ov; e.e = m_err;
        q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk("sb_data",  32'(out_data),  32'(e.d));
            chk("sb_ch",    32'(out_ch),    32'(e.ch));
            chk("sb_valid", 32'(out_valid), 32'(e.v));
            chk("sb_err",   32'(sel_err),   32'(e.e));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"},  32'(out_data),  32'd0);
        chk({tag, "_ch"},    32'(out_ch),    32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_err"},   32'(sel_err),   32'd0);
    endtask

    initial begin
        model_reset();
        #12;
        check_zero("reset");
        rst = 1'b0;

        // idle: nothing selected yet
        in_data = {8'h33, 8'h22, 8'h11};
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);

        // select channel 2: visible after two edges
        sel = 2'd2; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        chk("sel_lat1_valid", 32'(out_valid), 32'd0);
        step();
        chk("sel_data", 32'(out_data), 32'h33);
        chk("sel_ch",   32'(out_ch),   32'd2);
        chk("sel_valid", 32'(out_valid), 32'd1);

        // held channel follows its data in one edge; others ignored
        in_data[2*W +: W] = 8'hA5;
        step();
        chk("follow_data", 32'(out_data), 32'hA5);
        in_data[0 +: W] = 8'h5A;
        in_data[W +: W] = 8'hC3;
        step();
        chk("other_ch_data", 32'(out_data), 32'hA5);

        // out-of-range select: one-cycle error, channel unchanged
        sel = 2'd3; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        chk("err_pulse", 32'(sel_err), 32'd1);
        step();
        chk("err_clear", 32'(sel_err), 32'd0);
        chk("err_ch",    32'(out_ch),  32'd2);
        step();
        chk("err_hold_ch", 32'(out_ch), 32'd2);

        // mode rises with sel_valid (sel=1)
        mode = 1'b1; sel = 2'd1; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
`ifdef MUX_SCAN_EN
        for (int i = 0; i < 10; i++) begin
            step();
            chk("scan_seq", 32'(out_ch), 32'(scan_seq[i]));
        end
        step();
        step();
        step();
        chk("scan_ch1", 32'(out_ch), 32'd1);
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("scan_exit_hold", 32'(out_ch), 32'd1);
        end

        // reset mid-scan
        mode = 1'b1;
        for (int i = 0; i < 4; i++) step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_zero("rst_mid_scan");
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("rescan_valid", 32'(out_valid), 32'd1);
`else
        // mode ignored: sel applies as in HOLD
        step();
        chk("noscan_ch", 32'(out_ch), 32'd1);
        chk("noscan_data", 32'(out_data), 32'hC3);

        // reset, then mode=1 alone keeps the block idle
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_zero("rst_mid_hold");
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("noscan_idle", 32'(out_valid), 32'd0);
        end
        sel = 2'd0; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        step();
        chk("noscan_sel_data", 32'(out_data), 32'h5A);
        chk("noscan_sel_valid", 32'(out_valid), 32'd1);
`endif
        mode = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
